// File: rtl/sram_ctrl_pkg.sv
// Shared FSM encoding, default CPU-to-SRAM mapping and the word-index helper
// for the 32-bit to 16-bit SRAM bridge.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int DEFAULT_BASE_ADDR = 1024;

    function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_read_buffer.sv
// One-entry read buffer {valid, word, data}: misses fill it, writes to the held word update it.
// Lookup is combinational; updates land on the clock after upd_en.
// No backpressure: accepts an update every cycle.
module sram_read_buffer #(
    parameter int WW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WW-1:0] lookup_w,
    output logic          hit,
    output logic [31:0]   hit_data,
    input  logic          upd_en,
    input  logic          upd_fill,
    input  logic [WW-1:0] upd_w,
    input  logic [31:0]   upd_data
);

    logic          vld_q;
    logic [WW-1:0] w_q;
    logic [31:0]   data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            w_q    <= '0;
            data_q <= '0;
        end else if (upd_en) begin
            if (upd_fill) begin
                vld_q  <= 1'b1;
                w_q    <= upd_w;
                data_q <= upd_data;
            end else if (vld_q && (w_q == upd_w)) begin
                data_q <= upd_data;
            end
        end
    end

    assign hit      = vld_q && (w_q == lookup_w);
    assign hit_data = data_q;

endmodule

// File: rtl/sram_controller.sv
// 32-bit word access over a 16-bit async SRAM as two half-word transactions (SRAM_CTRL_RD_BUF_EN adds a read buffer).
// Latency: 2*WAIT_CYCLES+1 cycles of ready=0, data visible in the DONE cycle; buffer hits complete in the request cycle.
// Backpressure: ready=0 freezes the pipeline; requests must be held until ready returns high.
import sram_ctrl_pkg::*;

module sram_controller #(
    parameter int WAIT_CYCLES = 6,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n
);

    localparam int             CW   = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0]  HOLD = CW'(WAIT_CYCLES - 2);

    sram_state_t        state;
    logic [CW-1:0]      count;
    logic               is_wr;
    logic [31:0]        wr_data_q;
    logic [31:0]        read_data_q;
    logic               we_n_q;
    logic [SRAM_AW-1:0] addr_q;
    logic               dq_oe;
    logic [15:0]        dq_out;

    logic               req;
    logic [31:0]        word_full;
    logic [SRAM_AW-2:0] req_w;
    logic               unused_word_bits;
    logic               buf_hit;
    logic [31:0]        buf_data;
    logic               hit_now;

    assign req              = rd_en | wr_en;
    assign word_full        = word_index(address, 32'(BASE_ADDR));
    assign req_w            = word_full[SRAM_AW-2:0];
    assign unused_word_bits = ^word_full[31:SRAM_AW-1];

`ifdef SRAM_CTRL_RD_BUF_EN
    sram_read_buffer #(.WW(SRAM_AW-1)) u_rd_buf (
        .clk      (clk),
        .rst      (rst),
        .lookup_w (req_w),
        .hit      (buf_hit),
        .hit_data (buf_data),
        .upd_en   (state == DONE),
        .upd_fill (~is_wr),
        .upd_w    (addr_q[SRAM_AW-1:1]),
        .upd_data (is_wr ? wr_data_q : read_data_q)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // Write wins over read, so a buffer hit needs a pure read.
    assign hit_now = (state == IDLE) && rd_en && !wr_en && buf_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            is_wr       <= 1'b0;
            wr_data_q   <= '0;
            read_data_q <= '0;
            we_n_q      <= 1'b1;
            addr_q      <= '0;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit_now) begin
                        read_data_q <= buf_data;
                    end else if (req) begin
                        state     <= LOW;
                        count     <= '0;
                        is_wr     <= wr_en;
                        wr_data_q <= write_data;
                        addr_q    <= {req_w, 1'b0};
                        we_n_q    <= ~wr_en;
                        dq_oe     <= wr_en;
                        dq_out    <= write_data[15:0];
                    end
                end
                LOW, HIGH: begin
                    if (count == LAST) begin
                        count <= '0;
                        if (!is_wr) begin
                            if (state == LOW) read_data_q[15:0]  <= sram_dq;
                            else              read_data_q[31:16] <= sram_dq;
                        end
                        if (state == LOW) begin
                            state     <= HIGH;
                            addr_q[0] <= 1'b1;
                            we_n_q    <= ~is_wr;
                            dq_out    <= wr_data_q[31:16];
                        end else begin
                            state  <= DONE;
                            we_n_q <= 1'b1;
                            dq_oe  <= 1'b0;
                        end
                    end else begin
                        count <= count + 1'b1;
                        // Last count of each half keeps data on the bus with WE released.
                        if (count == HOLD) we_n_q <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = ~req | hit_now;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign read_data = hit_now ? buf_data : read_data_q;
    assign sram_dq   = dq_oe ? dq_out : 16'bz;
    assign sram_addr = addr_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller against a 256K x 16 tri-state SRAM model.
module tb_sram_controller;

    localparam int WAIT   = 6;
    localparam int FREEZE = 2 * WAIT + 1;
    localparam int WEL    = 2 * (WAIT - 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

    sram_controller #(.WAIT_CYCLES(WAIT), .BASE_ADDR(1024), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .sram_dq(sram_dq),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    // SRAM model: drives dq for bench-issued reads, commits writes on the WE rising edge.
    logic [15:0] mem [0:262143];
    logic        bus_rd = 1'b0;
    logic        tb_force = 1'b0;
    logic [17:0] wr_addr_l = '0;
    logic [15:0] wr_dat_l = '0;

    assign sram_dq = tb_force ? 16'h5A5A : ((bus_rd && sram_we_n) ? mem[sram_addr] : 16'bz);

    always @(negedge sram_we_n) wr_addr_l = sram_addr;
    always @(posedge clk) if (!sram_we_n) wr_dat_l = sram_dq;
    always @(posedge sram_we_n) mem[wr_addr_l] = wr_dat_l;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          freeze;
        logic [17:0] lo;
        logic [17:0] hi;
        int          wel;
    } exp_t;

    exp_t sb_q[$];
    logic mon_en = 1'b0;
    int   frz = 0;
    int   wel_cnt = 0;
    logic [17:0] lo_seen = '0, hi_seen = '0;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            frz = 0;
            wel_cnt = 0;
        end else if (rd_en || wr_en) begin
            if (!sram_we_n) wel_cnt++;
            if (!ready) begin
                frz++;
                if (frz == 2)        lo_seen = sram_addr;
                if (frz == WAIT + 2) hi_seen = sram_addr;
            end else begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: completion with no expected entry");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("read_data", read_data, e.data);
                    check("freeze_len", 32'(frz), 32'(e.freeze));
                    check("we_low_cycles", 32'(wel_cnt), 32'(e.wel));
                    if (e.freeze != 0) begin
                        check("lo_addr", 32'(lo_seen), 32'(e.lo));
                        check("hi_addr", 32'(hi_seen), 32'(e.hi));
                    end
                end
                frz = 0;
                wel_cnt = 0;
            end
        end
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input int freeze, input logic [17:0] lo, input logic [17:0] hi,
                          input int wel, input logic b2b);
        exp_t e;
        bit   done;
        e.data = exp_data; e.freeze = freeze; e.lo = lo; e.hi = hi; e.wel = wel;
        sb_q.push_back(e);
        rd_en = rd; wr_en = wr; address = addr; write_data = wdata; bus_rd = rd & ~wr;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout: ready never returned for addr 0x%08h", addr);
        end
        @(posedge clk);
        #1;
        if (!b2b) begin
            rd_en = 1'b0; wr_en = 1'b0; bus_rd = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
        mem[2] = 16'h3344;
        mem[3] = 16'h1122;

        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Word write and read-back, plus a preloaded word at the next index.
        do_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, FREEZE, 18'd0, 18'd1, WEL, 1'b0);
        check("mem0", 32'(mem[0]), 32'h0000BEEF);
        check("mem1", 32'(mem[1]), 32'h0000DEAD);
        do_req(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, FREEZE, 18'd0, 18'd1, 0, 1'b0);
        do_req(1'b1, 1'b0, 32'd1028, 32'h0, 32'h11223344, FREEZE, 18'd2, 18'd3, 0, 1'b0);

        // Asynchronous reset landing in the high half of a write.
        mon_en = 1'b0;
        wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", 32'(ready), 32'd0);
        check("pre_rst_hi_addr", 32'(sram_addr), 32'd9);
        wr_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_we_n", 32'(sram_we_n), 32'd1);
        check("arst_addr", 32'(sram_addr), 32'd0);
        check("arst_read_data", read_data, 32'h0);
        tb_force = 1'b1;
        #1;
        check("arst_dq_released", 32'(sram_dq), 32'h00005A5A);
        tb_force = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        do_req(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 32'h0, FREEZE, 18'd8, 18'd9, WEL, 1'b0);
        do_req(1'b1, 1'b0, 32'd1040, 32'h0, 32'hCAFEF00D, FREEZE, 18'd8, 18'd9, 0, 1'b0);

        // Read and write together: write wins, read_data keeps the last load.
        do_req(1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hCAFEF00D, FREEZE, 18'd4, 18'd5, WEL, 1'b0);
        check("mem4", 32'(mem[4]), 32'h00005678);
        check("mem5", 32'(mem[5]), 32'h00001234);

        // Back-to-back requests with no idle gap.
        do_req(1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678, FREEZE, 18'd4, 18'd5, 0, 1'b1);
        do_req(1'b0, 1'b1, 32'd1036, 32'hA5A55A5A, 32'h12345678, FREEZE, 18'd6, 18'd7, WEL, 1'b1);
        do_req(1'b1, 1'b0, 32'd1036, 32'h0, 32'hA5A55A5A, FREEZE, 18'd6, 18'd7, 0, 1'b0);

`ifdef SRAM_CTRL_RD_BUF_EN
        do_req(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, FREEZE, 18'd0, 18'd1, 0, 1'b0);
        do_req(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 0, 18'd0, 18'd0, 0, 1'b0);
        do_req(1'b0, 1'b1, 32'd1024, 32'h00000001, 32'hDEADBEEF, FREEZE, 18'd0, 18'd1, WEL, 1'b0);
        do_req(1'b1, 1'b0, 32'd1024, 32'h0, 32'h00000001, 0, 18'd0, 18'd0, 0, 1'b0);
        check("buf_hold_after_hit", read_data, 32'h00000001);
`endif

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
